// File: rtl/serial_comp_seq.sv
// Bit-serial unsigned magnitude comparator: scans A/B MSB-first, one bit pair per clock,
// and presents a registered one-hot gt/lt/eq result with a single-cycle done pulse.
module serial_comp_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             fgt_q, fgt_d;
  logic             flt_q, flt_d;
  logic             feq_q, feq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             bit_a, bit_b;

  // Operands shift left each RUN edge, so the bit under examination is always the MSB.
  assign bit_a = a_q[WIDTH-1];
  assign bit_b = b_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    fgt_d   = fgt_q;
    flt_d   = flt_q;
    feq_d   = feq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IW'(WIDTH - 1);
          feq_d   = 1'b1;
          fgt_d   = 1'b0;
          flt_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Only the first differing pair decides; once eq drops the flags are frozen.
        if (feq_q && (bit_a != bit_b)) begin
          fgt_d = bit_a;
          flt_d = bit_b;
          feq_d = 1'b0;
        end
        a_d = a_q << 1;
        b_d = b_q << 1;
        if (idx_q == '0) begin
          gt_d    = fgt_d;
          lt_d    = flt_d;
          eq_d    = feq_d;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      fgt_q   <= 1'b0;
      flt_q   <= 1'b0;
      feq_q   <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      fgt_q   <= fgt_d;
      flt_q   <= flt_d;
      feq_q   <= feq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign eq   = eq_q;

endmodule

// File: doc/serial_comp_seq.md
SERIAL_COMP_SEQ -- requirements
Module: serial_comp_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 1 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to compare a against b.
REQ-005 The block SHALL have port a, input, WIDTH bits: unsigned operand A, sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: unsigned operand B, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a comparison is in progress (RUN or DONE state).
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a new valid result.
REQ-009 The block SHALL have ports gt, lt and eq, outputs, 1 bit each: registered result (A>B, A<B, A==B).

Function
REQ-010 The block SHALL implement a Moore FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1 at a clock edge, the block SHALL capture a and b into internal registers, set bit index to WIDTH-1, set internal decision flags to eq=1/gt=0/lt=0, and enter RUN.
REQ-012 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-013 Each RUN edge SHALL examine exactly one bit pair {A[idx],B[idx]}, MSB first, with the 1-bit rules 00/11 -> equal, 10 -> greater, 01 -> less.
REQ-014 The first differing bit pair SHALL decide the result: when the internal eq flag is 1 and the bits differ, set gt or lt and clear eq; once eq is 0, later bits SHALL NOT change the flags.
REQ-015 RUN SHALL last exactly WIDTH edges with no early termination; at the edge processing idx=0, the block SHALL enter DONE, otherwise it SHALL decrement idx.
REQ-016 At the RUN->DONE edge, the block SHALL load the final flags, including the bit-0 decision, into the gt/lt/eq outputs.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE unconditionally.
REQ-018 Latency: when start is accepted at edge E0, done SHALL be high in the cycle following edge E0+WIDTH.
REQ-019 gt/lt/eq SHALL hold their last loaded value through IDLE and through any subsequent RUN until the next RUN->DONE edge.
REQ-020 Exactly one of gt/lt/eq SHALL be 1 at all times after the first completed comparison.
REQ-021 start SHALL be ignored while in RUN or DONE, and a or b changes SHALL NOT affect an in-progress comparison.
REQ-022 A start held high continuously SHALL be accepted again in the first IDLE cycle after DONE, giving back-to-back comparisons every WIDTH+2 cycles.
REQ-023 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-024 With WIDTH=1, RUN SHALL last one edge and the block SHALL follow all rules above.

Reset
REQ-025 Assertion of rst SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, gt=0, lt=0, eq=0, idx=0, and clear the captured operands.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the comparison with no done pulse, and the outputs SHALL read all-zero until the next completed comparison.
REQ-027 After rst deasserts, the block SHALL sample start on the first clock edge.

Verification
REQ-028 With WIDTH=8, the bench SHALL check: start with a=0xA5, b=0xA5 -> done 9 edges after accept, eq=1, gt=0, lt=0.
REQ-029 The bench SHALL check: a=0x80, b=0x7F -> gt=1 (decided at the MSB, later bits ignored); then a=0x01, b=0x02 -> lt=1 (decided at bit 1; bit 0 pair 1/0 ignored).
REQ-030 The bench SHALL check: start held high for 30 cycles with constant a=0x10, b=0x20 -> done pulses every 10 cycles, lt=1 each time, and busy low for exactly one cycle between runs.
REQ-031 The bench SHALL check: a=0x00, b=0xFF accepted, then a,b changed and start pulsed during RUN -> the result still gives lt=1 and start is ignored.
REQ-032 The bench SHALL check: rst asserted 4 cycles into RUN -> busy, done, gt, lt and eq read 0 asynchronously; a new start with a=0xFF, b=0x00 then gives gt=1.
REQ-033 The bench SHALL check, for WIDTH=1, all four a/b combinations -> done 1 edge after the RUN edge, with results 00/11 -> eq, 10 -> gt, 01 -> lt.
